// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: scan sequencer for a 4-digit multiplexed seven-segment display.
// Produces the digit index, the nibble for the BCD decoder and the active-low
// anode pattern, with guard blanking at each slot start, optional leading-zero
// blanking and a double-buffered display word loaded over valid/ready.
// Optional brightness control is compiled in when SSD_DIM_EN is defined.
module ssd_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 4,
    parameter int unsigned CNT_W    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        lz_blank,
`ifdef SSD_DIM_EN
    input  logic [2:0]  bright,
`endif
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    output logic [3:0]  digit_o,
    output logic [3:0]  ssd_ctrl,
    output logic [1:0]  scan_idx,
    output logic        frame_done
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       active_q, active_d;
    logic [15:0]       pend_q, pend_d;
    logic              pendFull_q, pendFull_d;
    logic [3:0]        ssd_q, ssd_d;
    logic [3:0]        digit_q, digit_d;
    logic              frameDone_q, frameDone_d;
    logic              blank;
    logic              anodeOn;
`ifdef SSD_DIM_EN
    logic [2:0]        bright_q, bright_d;
    logic [31:0]       onTime;
    logic [31:0]       sinceGuard;
    logic              dimOn;
`endif

    // Next-state logic: scan FSM, slot counter/index, and the pending->active word transfer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pendFull_d  = pendFull_q;
        frameDone_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = 2'd0;
                if (en) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end else if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    idx_d       = idx_q + 2'd1;
                    frameDone_d = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A full pending buffer blocks capture, so transfer and capture never coincide
        if (pendFull_q && ((state_q == IDLE) || frameDone_d)) begin
            active_d   = pend_q;
            pendFull_d = 1'b0;
        end else if (load_valid && !pendFull_q) begin
            pend_d     = load_data;
            pendFull_d = 1'b1;
        end
    end

    // Output decode from next-state values so the registered outputs track the new slot/count
    always_comb begin
        digit_d = 4'h0;
        blank   = 1'b0;
        case (idx_d)
            2'd0: begin
                digit_d = active_d[15:12];
                blank   = lz_blank && (active_d[15:12] == 4'h0);
            end
            2'd1: begin
                digit_d = active_d[11:8];
                blank   = lz_blank && (active_d[15:8] == 8'h00);
            end
            2'd2: begin
                digit_d = active_d[7:4];
                blank   = lz_blank && (active_d[15:4] == 12'h000);
            end
            default: begin
                digit_d = active_d[3:0];
                blank   = 1'b0;
            end
        endcase

`ifdef SSD_DIM_EN
        bright_d   = (cnt_d == '0) ? bright : bright_q;
        sinceGuard = 32'(cnt_d) - 32'(GUARD);
        onTime     = ((PRESCALE - GUARD) >> 3) * (32'(bright_d) + 32'd1);
        dimOn      = (sinceGuard < onTime);
        anodeOn    = (state_d == SCAN) && !(cnt_d < GUARD_C) && !blank && dimOn;
`else
        anodeOn    = (state_d == SCAN) && !(cnt_d < GUARD_C) && !blank;
`endif

        ssd_d = anodeOn ? ~(4'b1000 >> idx_d) : 4'hF;
    end

    // State and output registers; reset darkens the display and empties both buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            active_q    <= 16'h0000;
            pend_q      <= 16'h0000;
            pendFull_q  <= 1'b0;
            ssd_q       <= 4'hF;
            digit_q     <= 4'h0;
            frameDone_q <= 1'b0;
`ifdef SSD_DIM_EN
            bright_q    <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pendFull_q  <= pendFull_d;
            ssd_q       <= ssd_d;
            digit_q     <= digit_d;
            frameDone_q <= frameDone_d;
`ifdef SSD_DIM_EN
            bright_q    <= bright_d;
`endif
        end
    end

    assign load_ready = ~pendFull_q;
    assign digit_o    = digit_q;
    assign ssd_ctrl   = ssd_q;
    assign scan_idx   = idx_q;
    assign frame_done = frameDone_q;

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Sequencer for the 4-digit seven-segment display mux.
- Generates the time-multiplexed digit select and the active-low anode controls. Holds a double-buffered 16-bit display word, and inserts guard blanking between digits to suppress ghosting.
- Optional leading-zero blanking.
- Sits between application logic, which posts words through a valid/ready handshake, and the BCD-to-segment decoder.

Parameters:
- PRESCALE, 50000: clk cycles per digit slot (500 Hz frame at 100 MHz); legal 4..2^20.
- GUARD, 4: cycles at the start of each slot with all anodes off; legal 0..PRESCALE-1.
- CNT_W, 20: slot counter width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable; 0 = display dark.
- lz_blank  in  1  1 = blank leading zero digits.
- load_valid  in  1  new display word offered.
- load_ready  out  1  pending buffer empty; word accepted when valid & ready.
- load_data  in  16  [15:12] = digit 0 (leftmost) ... [3:0] = digit 3 (rightmost).
- digit_o  out  4  nibble of the currently scanned digit, to the decoder.
- ssd_ctrl  out  4  active-low anodes: digit0=0111, digit1=1011, digit2=1101, digit3=1110, off=1111.
- scan_idx  out  2  currently scanned digit index.
- frame_done  out  1  one-cycle pulse at the end of digit 3's slot.

Behaviour:
- All outputs are registered.
- Reset values:
  - ssd_ctrl=1111, digit_o=0, scan_idx=0, frame_done=0, load_ready=1.
  - Active word = 0, pending buffer empty, slot counter = 0.
  - State = IDLE.
- States:
  - IDLE: en=0. ssd_ctrl=1111, counter=0, idx=0.
  - SCAN: en=1.
  - Transition IDLE->SCAN on the first clk edge with en=1; that cycle starts slot 0 at count 0.
  - SCAN->IDLE on the first edge with en=0, from any count or idx. The active word is retained; a pending word stays pending.
- Slot timing in SCAN:
  - Counter runs 0..PRESCALE-1.
  - When count=PRESCALE-1: count->0, idx->idx+1 (3 wraps to 0).
  - frame_done=1 for exactly the cycle after the edge where idx 3 wraps to 0.
- Outputs per cycle:
  - digit_o = active[15-4*idx -: 4], updated with idx.
  - ssd_ctrl = 1111 while count < GUARD, or while the digit is blanked; otherwise the anode pattern for idx.
  - GUARD=0 means no guard cycles.
- Leading-zero blanking: with lz_blank=1, digit k (k<3) is blanked iff digits 0..k of the active word are all 0. Digit 3 is never blanked, so 0x0000 shows a single "0".
- Load handshake:
  - load_ready = !pending_full.
  - On valid & ready, the word is captured into pending and pending_full is set.
  - Pending transfers to active:
    - at the frame boundary (edge where idx 3 -> 0), or
    - on any edge while in IDLE.
  - pending_full clears on that same edge, so load_ready=1 the following cycle.
- Boundary cases:
  - Word accepted on the frame-boundary edge: it is not transferred until the next boundary. Transfer only uses pending_full as registered before that edge.
  - load_valid held with ready=0: no capture, no data loss; the source holds.
  - Back-to-back words: at most one pending; the second stalls until the next transfer.
  - Reset mid-slot: immediate dark (1111), both buffers cleared.

Optional Feature:
- Macro: SSD_DIM_EN.
- Defined:
  - Adds input port bright[2:0].
  - Anodes are active only while (count-GUARD) < ((PRESCALE-GUARD)>>3)*(bright+1), in addition to all rules above.
  - bright=7 gives an on-time of 8*floor((PRESCALE-GUARD)/8) cycles. bright is sampled at each slot start (count=0).
- Undefined: no bright port; full on-time after the guard interval.

Test Plan:
- Use PRESCALE=8, GUARD=2 for all scenarios.
- Reset, then en=1 with active 0x0000 and lz_blank=0:
  - ssd_ctrl sequence per slot is 1111,1111, then 0111 x6; next slot 1111,1111, then 1011 x6, etc.
  - frame_done pulses every 32 cycles.
- Load 0x1234 during slot 1:
  - load_ready drops the next cycle.
  - digit_o stays 0 until the frame boundary, then shows 1,2,3,4 over slots 0..3.
  - load_ready returns to 1 after the boundary.
- lz_blank=1 with active 0x0050:
  - Slots 0 and 1 stay 1111 for the whole slot.
  - Slot 2 shows 5; slot 3 shows 0.
- Offer 0xAAAA, then 0xBBBB on consecutive cycles:
  - 0xBBBB is stalled (ready=0) until the boundary.
  - Active becomes 0xAAAA at boundary 1 and 0xBBBB at boundary 2.
- en drop in mid slot 2: next cycle ssd_ctrl=1111, scan_idx=0; en re-asserted restarts at slot 0, count 0.
- SSD_DIM_EN with bright=0: anodes are active for 0 cycles per slot ((6>>3)*1 = 0). Repeat with PRESCALE=18: active for exactly 2 cycles after the guard.
